// File: rtl/pxl_frame_collector_if.sv
// Bus bundle for pxl_frame_collector: pixel stream in, random-access readback and frame status.
// The master side is the stream source or readback client; the slave side is the collector.
interface pxl_frame_collector_if #(
   parameter int D          = 299,
   parameter int data_width = 32
);
   localparam int AW = $clog2(D*D);

   logic                  valid_in;
   logic [data_width-1:0] pxl_in;
   logic                  clear;
   logic                  rd_en;
   logic [AW-1:0]         rd_addr;
   logic [data_width-1:0] rd_data;
   logic                  rd_valid;
   logic [AW-1:0]         row;
   logic [AW-1:0]         col;
   logic                  frame_done;
   logic                  frame_ready;
   logic                  overflow;
   logic [data_width-1:0] checksum;

   modport master (
      output valid_in, pxl_in, clear, rd_en, rd_addr,
      input  rd_data, rd_valid, row, col, frame_done, frame_ready, overflow, checksum
   );

   modport slave (
      input  valid_in, pxl_in, clear, rd_en, rd_addr,
      output rd_data, rd_valid, row, col, frame_done, frame_ready, overflow, checksum
   );
endinterface

// File: rtl/pxl_frame_collector.sv
// Captures one D x D pixel frame in raster order into a synchronous RAM, with a running
// checksum, completion/overflow flags and a registered 1-cycle-latency readback port.
module pxl_frame_collector #(
   parameter int D          = 299,
   parameter int data_width = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   pxl_frame_collector_if.slave    bus
);
   localparam int          AW   = $clog2(D*D);
   localparam int unsigned NPIX = D*D;
   localparam logic [AW-1:0] LAST = AW'(D-1);
   localparam logic [AW-1:0] ONE  = AW'(1);

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_DONE    = 1'b1
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic                  accept_s;
   logic                  ovf_set_s;
   logic                  last_s;
   logic                  rd_in_range_s;
   logic [AW-1:0]         row_r;
   logic [AW-1:0]         col_r;
   logic [AW-1:0]         wr_addr_r;
   logic [data_width-1:0] checksum_r;
   logic                  frame_done_r;
   logic                  frame_ready_r;
   logic                  overflow_r;
   logic [data_width-1:0] rd_data_r;
   logic                  rd_valid_r;
   logic [data_width-1:0] mem [0:NPIX-1];

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_COLLECT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state: clear always returns to collection, last accepted pixel completes the frame.
   always_comb begin
      state_nxt_s = state_r;
      if (bus.clear) begin
         state_nxt_s = ST_COLLECT;
      end else begin
         case (state_r)
            ST_COLLECT: begin
               if (last_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_COLLECT;
               end
            end
            ST_DONE:  state_nxt_s = ST_DONE;
            default:  state_nxt_s = ST_COLLECT;
         endcase
      end
   end

   // Output decode: a strobe is either stored (collecting) or flagged as overflow (frame held).
   always_comb begin
      accept_s  = 1'b0;
      ovf_set_s = 1'b0;
      case (state_r)
         ST_COLLECT: begin
            accept_s  = bus.valid_in & ~bus.clear;
            ovf_set_s = 1'b0;
         end
         ST_DONE: begin
            accept_s  = 1'b0;
            ovf_set_s = bus.valid_in & ~bus.clear;
         end
         default: begin
            accept_s  = 1'b0;
            ovf_set_s = 1'b0;
         end
      endcase
   end

   assign last_s = accept_s && (row_r == LAST) && (col_r == LAST);

   // Raster position, linear write address, checksum and frame status flags.
   always_ff @(posedge clk) begin
      if (!reset || bus.clear) begin
         row_r         <= {AW{1'b0}};
         col_r         <= {AW{1'b0}};
         wr_addr_r     <= {AW{1'b0}};
         checksum_r    <= {data_width{1'b0}};
         frame_done_r  <= 1'b0;
         frame_ready_r <= 1'b0;
         overflow_r    <= 1'b0;
      end else begin
         frame_done_r <= last_s;
         if (accept_s) begin
            checksum_r <= checksum_r + bus.pxl_in;
            if (last_s) begin
               row_r     <= {AW{1'b0}};
               col_r     <= {AW{1'b0}};
               wr_addr_r <= {AW{1'b0}};
            end else if (col_r == LAST) begin
               row_r     <= row_r + ONE;
               col_r     <= {AW{1'b0}};
               wr_addr_r <= wr_addr_r + ONE;
            end else begin
               col_r     <= col_r + ONE;
               wr_addr_r <= wr_addr_r + ONE;
            end
         end
         if (last_s) begin
            frame_ready_r <= 1'b1;
         end
         if (ovf_set_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Frame buffer write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem[wr_addr_r] <= bus.pxl_in;
      end
   end

   assign rd_in_range_s = (32'(bus.rd_addr) < NPIX);

   // Registered read port; nonblocking write above makes a same-address access return old data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_valid_r <= 1'b0;
         rd_data_r  <= {data_width{1'b0}};
      end else if (bus.rd_en) begin
         rd_valid_r <= 1'b1;
         rd_data_r  <= rd_in_range_s ? mem[bus.rd_addr] : {data_width{1'b0}};
      end else begin
         rd_valid_r <= 1'b0;
      end
   end

   assign bus.row         = row_r;
   assign bus.col         = col_r;
   assign bus.checksum    = checksum_r;
   assign bus.frame_done  = frame_done_r;
   assign bus.frame_ready = frame_ready_r;
   assign bus.overflow    = overflow_r;
   assign bus.rd_data     = rd_data_r;
   assign bus.rd_valid    = rd_valid_r;
endmodule
